// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and address/data types for the regfile_sb register file.
package regfile_pkg;
   localparam int WIDTH_D    = 64;
   localparam int DEPTH_D    = 32;
   localparam int NREAD_D    = 2;
   localparam int ZERO_REG_D = 31;
   typedef logic [4:0]  reg_addr_t;
   typedef logic [63:0] reg_data_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending bits set at issue, cleared at write-back, with a running count.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int  DEPTH    = DEPTH_D,
   parameter int  NREAD    = NREAD_D,
   parameter int  ZERO_REG = DEPTH - 1,
   localparam int AW       = $clog2(DEPTH)
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [AW-1:0]             i_issue_addr,
   input  logic                      i_issue_valid,
   input  logic [AW-1:0]             i_wb_addr,
   input  logic                      i_wb_valid,
   input  logic [NREAD-1:0][AW-1:0]  i_lookup_addr,
   output logic [NREAD-1:0]          o_busy,
   output logic [AW:0]               o_count
);
   localparam logic [AW-1:0] ZR = AW'(ZERO_REG);
   logic [DEPTH-1:0] r_pend;
   logic [DEPTH-1:0] w_next;
   logic [AW:0]      r_count;
   logic             w_set;
   logic             w_clr;
   // A same-register issue keeps the bit set, so that write-back must not count as a clear.
   assign w_set = i_issue_valid && i_issue_addr != ZR && !r_pend[i_issue_addr];
   assign w_clr = i_wb_valid && r_pend[i_wb_addr] && !(i_issue_valid && i_issue_addr == i_wb_addr);
   always_comb begin
      w_next = r_pend;
      if (w_clr) w_next[i_wb_addr] = 1'b0;
      if (w_set) w_next[i_issue_addr] = 1'b1;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pend  <= '0;
         r_count <= '0;
      end else begin
         r_pend  <= w_next;
         r_count <= r_count + (AW+1)'(w_set) - (AW+1)'(w_clr);
      end
   end
   for (genvar g = 0; g < NREAD; g++) begin : g_lookup
      assign o_busy[g] = r_pend[i_lookup_addr[g]];
   end
   assign o_count = r_count;
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with hardwired zero register and pending scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write-back data and readiness to the read ports.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int  WIDTH    = WIDTH_D,
   parameter int  DEPTH    = DEPTH_D,
   parameter int  NREAD    = NREAD_D,
   parameter int  ZERO_REG = DEPTH - 1,
   localparam int AW       = $clog2(DEPTH)
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [NREAD-1:0][AW-1:0]    ReadRegister,
   output logic [NREAD-1:0][WIDTH-1:0] ReadData,
   output logic [NREAD-1:0]            ReadReady,
   input  logic [AW-1:0]               WriteRegister,
   input  logic [WIDTH-1:0]            WriteData,
   input  logic                        RegWrite,
   input  logic [AW-1:0]               IssueRegister,
   input  logic                        IssueValid,
   output logic [AW:0]                 PendingCount
);
   localparam logic [AW-1:0] ZR = AW'(ZERO_REG);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [NREAD-1:0] w_busy;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      else if (RegWrite && WriteRegister != ZR) r_mem[WriteRegister] <= WriteData;
   end
   regfile_scoreboard #(.DEPTH(DEPTH), .NREAD(NREAD), .ZERO_REG(ZERO_REG)) u_sb (
      .clk           (clk),
      .reset_n       (reset_n),
      .i_issue_addr  (IssueRegister),
      .i_issue_valid (IssueValid),
      .i_wb_addr     (WriteRegister),
      .i_wb_valid    (RegWrite),
      .i_lookup_addr (ReadRegister),
      .o_busy        (w_busy),
      .o_count       (PendingCount)
   );
   for (genvar g = 0; g < NREAD; g++) begin : g_rd
      logic [WIDTH-1:0] w_stored;
      assign w_stored = (ReadRegister[g] == ZR) ? '0 : r_mem[ReadRegister[g]];
`ifdef REGFILE_BYPASS_EN
      logic w_fwd;
      // Forwarding is suppressed during reset so ReadData stays zero while cleared.
      assign w_fwd = reset_n && RegWrite && WriteRegister == ReadRegister[g] && WriteRegister != ZR;
      assign ReadData[g]  = w_fwd ? WriteData : w_stored;
      assign ReadReady[g] = w_fwd ? !(IssueValid && IssueRegister == ReadRegister[g]) : !w_busy[g];
`else
      assign ReadData[g]  = w_stored;
      assign ReadReady[g] = !w_busy[g];
`endif
   end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: self-checking bench for regfile_sb with a reference model and expectation queue.
module tb_regfile_sb;
   logic            clk = 1'b0;
   logic            reset_n = 1'b1;
   logic [1:0][4:0]  rd_addr;
   logic [1:0][63:0] rd_data;
   logic [1:0]       rd_rdy;
   logic [4:0]       wr_addr;
   logic [63:0]      wr_data;
   logic             reg_write;
   logic [4:0]       iss_addr;
   logic             iss_valid;
   logic [5:0]       pcnt;
   typedef struct {logic [63:0] d; logic r;} exp_t;
   exp_t        q[$];
   exp_t        e;
   logic [63:0] m_mem [32];
   bit          m_pend [32];
   int          tests = 0;
   int          fails = 0;

   always #5 clk = ~clk;

   regfile_sb dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .ReadRegister  (rd_addr),
      .ReadData      (rd_data),
      .ReadReady     (rd_rdy),
      .WriteRegister (wr_addr),
      .WriteData     (wr_data),
      .RegWrite      (reg_write),
      .IssueRegister (iss_addr),
      .IssueValid    (iss_valid),
      .PendingCount  (pcnt)
   );

   function automatic int pc();
      int n = 0;
      for (int i = 0; i < 32; i++) n += int'(m_pend[i]);
      return n;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 32; i++) begin
         m_mem[i]  = '0;
         m_pend[i] = 1'b0;
      end
   endtask

   task automatic cycle(input logic w, input logic [4:0] wa, input logic [63:0] wd,
                        input logic iv, input logic [4:0] ia);
      reg_write = w; wr_addr = wa; wr_data = wd; iss_valid = iv; iss_addr = ia;
      @(posedge clk);
      if (w && wa != 5'd31) m_mem[wa] = wd;
      if (w) m_pend[wa] = 1'b0;
      if (iv && ia != 5'd31) m_pend[ia] = 1'b1;
      #1 reg_write = 1'b0; iss_valid = 1'b0;
   endtask

   task automatic push_reads(input logic [4:0] a0, input logic [4:0] a1);
      rd_addr[0] = a0; rd_addr[1] = a1;
      q.push_back('{m_mem[a0], !m_pend[a0]});
      q.push_back('{m_mem[a1], !m_pend[a1]});
   endtask

   task automatic test_reset();
      #2 reset_n = 1'b0;
      model_clear();
      repeat (2) @(posedge clk);
      push_reads(5'd0, 5'd31);
      #1;
      for (int k = 0; k < 2; k++) begin
         e = q.pop_front(); tests++;
         if (rd_data[k] !== e.d || rd_rdy[k] !== e.r) begin
            fails++; $display("FAIL reset_read[%0d]: got %h/%b want %h/%b", k, rd_data[k], rd_rdy[k], e.d, e.r);
         end
      end
      tests++;
      if (pcnt !== 6'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", pcnt); end
      reset_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_zero_reg();
      cycle(1'b1, 5'd31, 64'hA0, 1'b1, 5'd31);
      push_reads(5'd31, 5'd31);
      #1;
      for (int k = 0; k < 2; k++) begin
         e = q.pop_front(); tests++;
         if (rd_data[k] !== e.d || rd_rdy[k] !== e.r) begin
            fails++; $display("FAIL zero_reg[%0d]: got %h/%b want %h/%b", k, rd_data[k], rd_rdy[k], e.d, e.r);
         end
      end
      tests++;
      if (pcnt !== 6'd0) begin fails++; $display("FAIL zero_count: got %0d want 0", pcnt); end
   endtask

   task automatic test_fill();
      for (int i = 0; i < 31; i++) cycle(1'b1, 5'(i), 64'(i) * 64'h0000010204080001, 1'b0, 5'd0);
      for (int i = 0; i < 31; i++) begin
         push_reads(5'(i), 5'(30 - i));
         #1;
         for (int k = 0; k < 2; k++) begin
            e = q.pop_front(); tests++;
            if (rd_data[k] !== e.d || rd_rdy[k] !== e.r) begin
               fails++; $display("FAIL fill[%0d] x%0d: got %h/%b want %h/%b", k, rd_addr[k], rd_data[k], rd_rdy[k], e.d, e.r);
            end
         end
      end
   endtask

   task automatic test_issue_wb();
      cycle(1'b0, 5'd0, 64'd0, 1'b1, 5'd5);
      push_reads(5'd5, 5'd6);
      #1;
      for (int k = 0; k < 2; k++) begin
         e = q.pop_front(); tests++;
         if (rd_data[k] !== e.d || rd_rdy[k] !== e.r) begin
            fails++; $display("FAIL issue[%0d]: got %h/%b want %h/%b", k, rd_data[k], rd_rdy[k], e.d, e.r);
         end
      end
      tests++;
      if (pcnt !== 6'd1) begin fails++; $display("FAIL issue_count: got %0d want 1", pcnt); end
      cycle(1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
      cycle(1'b1, 5'd5, 64'hDEAD, 1'b0, 5'd0);
      push_reads(5'd5, 5'd5);
      #1;
      for (int k = 0; k < 2; k++) begin
         e = q.pop_front(); tests++;
         if (rd_data[k] !== e.d || rd_rdy[k] !== e.r) begin
            fails++; $display("FAIL writeback[%0d]: got %h/%b want %h/%b", k, rd_data[k], rd_rdy[k], e.d, e.r);
         end
      end
      tests++;
      if (pcnt !== 6'd0) begin fails++; $display("FAIL writeback_count: got %0d want 0", pcnt); end
   endtask

   task automatic test_same_cycle();
      cycle(1'b0, 5'd0, 64'd0, 1'b1, 5'd7);
      cycle(1'b1, 5'd7, 64'h77, 1'b1, 5'd7);
      cycle(1'b0, 5'd0, 64'd0, 1'b1, 5'd7);
      push_reads(5'd7, 5'd8);
      #1;
      for (int k = 0; k < 2; k++) begin
         e = q.pop_front(); tests++;
         if (rd_data[k] !== e.d || rd_rdy[k] !== e.r) begin
            fails++; $display("FAIL same_cycle[%0d]: got %h/%b want %h/%b", k, rd_data[k], rd_rdy[k], e.d, e.r);
         end
      end
      tests++;
      if (pcnt !== 6'd1) begin fails++; $display("FAIL same_cycle_count: got %0d want 1", pcnt); end
      cycle(1'b0, 5'd0, 64'd0, 1'b1, 5'd9);
      cycle(1'b1, 5'd9, 64'h99, 1'b1, 5'd10);
      cycle(1'b1, 5'd7, 64'h78, 1'b0, 5'd0);
      push_reads(5'd9, 5'd10);
      #1;
      for (int k = 0; k < 2; k++) begin
         e = q.pop_front(); tests++;
         if (rd_data[k] !== e.d || rd_rdy[k] !== e.r) begin
            fails++; $display("FAIL cross_bits[%0d]: got %h/%b want %h/%b", k, rd_data[k], rd_rdy[k], e.d, e.r);
         end
      end
      tests++;
      if (pcnt !== 6'(pc()) || pcnt !== 6'd1) begin fails++; $display("FAIL cross_count: got %0d want %0d", pcnt, pc()); end
      cycle(1'b1, 5'd10, 64'hA, 1'b0, 5'd0);
   endtask

   task automatic test_bypass();
      logic [63:0] old;
      cycle(1'b0, 5'd0, 64'd0, 1'b1, 5'd3);
      old = m_mem[3];
      reg_write = 1'b1; wr_addr = 5'd3; wr_data = 64'h55; rd_addr[0] = 5'd3; rd_addr[1] = 5'd4;
`ifdef REGFILE_BYPASS_EN
      q.push_back('{64'h55, 1'b1});
`else
      q.push_back('{old, 1'b0});
`endif
      #1;
      e = q.pop_front(); tests++;
      if (rd_data[0] !== e.d || rd_rdy[0] !== e.r) begin
         fails++; $display("FAIL bypass_same: got %h/%b want %h/%b", rd_data[0], rd_rdy[0], e.d, e.r);
      end
      @(posedge clk);
      m_mem[3] = 64'h55; m_pend[3] = 1'b0;
      #1 reg_write = 1'b0;
      push_reads(5'd3, 5'd3);
      #1;
      for (int k = 0; k < 2; k++) begin
         e = q.pop_front(); tests++;
         if (rd_data[k] !== e.d || rd_rdy[k] !== e.r) begin
            fails++; $display("FAIL bypass_after[%0d]: got %h/%b want %h/%b", k, rd_data[k], rd_rdy[k], e.d, e.r);
         end
      end
      tests++;
      if (pcnt !== 6'(pc())) begin fails++; $display("FAIL bypass_count: got %0d want %0d", pcnt, pc()); end
   endtask

   task automatic test_async_reset();
      cycle(1'b1, 5'd2, 64'h1234, 1'b0, 5'd0);
      cycle(1'b0, 5'd0, 64'd0, 1'b1, 5'd4);
      rd_addr[0] = 5'd2; rd_addr[1] = 5'd4;
      #1;
      tests++;
      if (rd_data[0] !== 64'h1234 || rd_rdy[1] !== 1'b0 || pcnt === 6'd0) begin
         fails++; $display("FAIL pre_reset: got %h/%b cnt %0d want 1234/0 nonzero", rd_data[0], rd_rdy[1], pcnt);
      end
      #2 reset_n = 1'b0;
      model_clear();
      reg_write = 1'b1; wr_addr = 5'd2; wr_data = 64'h99;
      push_reads(5'd2, 5'd4);
      #1;
      for (int k = 0; k < 2; k++) begin
         e = q.pop_front(); tests++;
         if (rd_data[k] !== e.d || rd_rdy[k] !== e.r) begin
            fails++; $display("FAIL async_reset[%0d]: got %h/%b want %h/%b", k, rd_data[k], rd_rdy[k], e.d, e.r);
         end
      end
      tests++;
      if (pcnt !== 6'd0) begin fails++; $display("FAIL async_count: got %0d want 0", pcnt); end
      @(posedge clk); #1;
      tests++;
      if (rd_data[0] !== 64'd0) begin fails++; $display("FAIL reset_hold_write: got %h want 0", rd_data[0]); end
      reg_write = 1'b0;
      reset_n = 1'b1;
      @(posedge clk);
      push_reads(5'd2, 5'd4);
      #1;
      for (int k = 0; k < 2; k++) begin
         e = q.pop_front(); tests++;
         if (rd_data[k] !== e.d || rd_rdy[k] !== e.r) begin
            fails++; $display("FAIL post_reset[%0d]: got %h/%b want %h/%b", k, rd_data[k], rd_rdy[k], e.d, e.r);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rd_addr = '0; wr_addr = '0; wr_data = '0; reg_write = 1'b0; iss_addr = '0; iss_valid = 1'b0;
      model_clear();
      test_reset();
      test_zero_reg();
      test_fill();
      test_issue_wb();
      test_same_cycle();
      test_bypass();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
